// File: rtl/debounce_multi.sv
// debounce_multi: N-channel push-button debouncer with 2-flop sync, shared sample-tick divider
// and per-channel stable-sample counters. Define DEBOUNCE_LONG_PRESS_EN to enable pb_long.
module debounce_multi #(
   parameter int N_CH       = 4,
   parameter int TICK_DIV   = 250000,
   parameter int STABLE_CNT = 4,
   parameter int LONG_TICKS = 200
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [N_CH-1:0] pb_raw,
   output logic [N_CH-1:0] pb_level,
   output logic [N_CH-1:0] pb_press,
   output logic [N_CH-1:0] pb_release,
   output logic            sample_tick,
   output logic [N_CH-1:0] pb_long
);

   localparam int DW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
   localparam logic [DW-1:0] DIV_MAX  = DW'(TICK_DIV - 1);
   localparam logic [SW-1:0] STAB_MAX = SW'(STABLE_CNT - 1);

   if (N_CH < 1 || TICK_DIV < 1 || STABLE_CNT < 1 || LONG_TICKS < 1) begin : g_param_check
      $error("debounce_multi: all parameters must be >= 1");
   end

   logic [N_CH-1:0] s1;
   logic [N_CH-1:0] s2;
   logic [DW-1:0]   cnt_div;
   logic [SW-1:0]   stab_cnt [N_CH];

   always_ff @(posedge clk) begin
      if (rst) begin
         s1 <= '0;
         s2 <= '0;
      end else begin
         s1 <= pb_raw;
         s2 <= s1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_div     <= '0;
         sample_tick <= 1'b0;
      end else begin
         sample_tick <= (cnt_div == DIV_MAX);
         if (cnt_div == DIV_MAX) cnt_div <= '0;
         else                    cnt_div <= cnt_div + DW'(1);
      end
   end

   // Any tick that sees s2 back at the current level throws away the partial count.
   always_ff @(posedge clk) begin
      if (rst) begin
         pb_level   <= '0;
         pb_press   <= '0;
         pb_release <= '0;
         for (int i = 0; i < N_CH; i++) stab_cnt[i] <= '0;
      end else begin
         pb_press   <= '0;
         pb_release <= '0;
         if (sample_tick) begin
            for (int i = 0; i < N_CH; i++) begin
               if (s2[i] == pb_level[i]) begin
                  stab_cnt[i] <= '0;
               end else if (stab_cnt[i] == STAB_MAX) begin
                  stab_cnt[i]   <= '0;
                  pb_level[i]   <= s2[i];
                  pb_press[i]   <= s2[i];
                  pb_release[i] <= ~s2[i];
               end else begin
                  stab_cnt[i] <= stab_cnt[i] + SW'(1);
               end
            end
         end
      end
   end

`ifdef DEBOUNCE_LONG_PRESS_EN
   localparam int LW = $clog2(LONG_TICKS + 1);
   localparam logic [LW-1:0] LONG_MAX = LW'(LONG_TICKS);
   localparam logic [LW-1:0] LONG_PRE = LW'(LONG_TICKS - 1);

   logic [LW-1:0] long_cnt [N_CH];

   // long_cnt saturates at LONG_TICKS so each press yields at most one pulse.
   always_ff @(posedge clk) begin
      if (rst) begin
         pb_long <= '0;
         for (int i = 0; i < N_CH; i++) long_cnt[i] <= '0;
      end else begin
         pb_long <= '0;
         for (int i = 0; i < N_CH; i++) begin
            if (!pb_level[i]) begin
               long_cnt[i] <= '0;
            end else if (sample_tick && long_cnt[i] != LONG_MAX) begin
               long_cnt[i] <= long_cnt[i] + LW'(1);
               if (long_cnt[i] == LONG_PRE) pb_long[i] <= 1'b1;
            end
         end
      end
   end
`else
   assign pb_long = '0;
`endif

endmodule

// File: tb/tb_debounce_multi.sv
// Bench for debounce_multi: stimulus table with a closed-form timing model feeding an event
// scoreboard; a negedge monitor matches press/release/long pulses and checks sample_tick.
module tb_debounce_multi;

   localparam int N_CH       = 2;
   localparam int TICK_DIV   = 4;
   localparam int STABLE_CNT = 3;
   localparam int LONG_TICKS = 5;
   localparam int K_PRESS = 0;
   localparam int K_REL   = 1;
   localparam int K_LONG  = 2;
`ifdef DEBOUNCE_LONG_PRESS_EN
   localparam bit LONG_EN = 1'b1;
`else
   localparam bit LONG_EN = 1'b0;
`endif

   logic            clk = 1'b0;
   logic            rst;
   logic [N_CH-1:0] pb_raw;
   logic [N_CH-1:0] pb_level;
   logic [N_CH-1:0] pb_press;
   logic [N_CH-1:0] pb_release;
   logic            sample_tick;
   logic [N_CH-1:0] pb_long;

   debounce_multi #(
      .N_CH(N_CH), .TICK_DIV(TICK_DIV), .STABLE_CNT(STABLE_CNT), .LONG_TICKS(LONG_TICKS)
   ) dut (
      .clk(clk), .rst(rst), .pb_raw(pb_raw), .pb_level(pb_level), .pb_press(pb_press),
      .pb_release(pb_release), .sample_tick(sample_tick), .pb_long(pb_long)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic            rst;
      logic [N_CH-1:0] raw;
      int              hold;
      logic [N_CH-1:0] exp_level;
   } vec_t;

   typedef struct {
      int t;
      int kind;
      int ch;
   } ev_t;

   vec_t  vec [22];
   ev_t   sb [$];
   int    checks = 0;
   int    errors = 0;
   int    cyc = 0;
   int    gcyc = 0;
   bit    mon_en = 1'b0;
   string kname [3] = '{"press", "release", "long"};

   // cyc counts edges since the last edge that sampled rst high
   always @(posedge clk) begin
      gcyc <= gcyc + 1;
      if (rst) cyc <= 0;
      else     cyc <= cyc + 1;
   end

   always @(negedge clk) begin
      if (mon_en) begin
         logic exp_tick;
         logic v;
         int   idx;
         exp_tick = (cyc > 0) && (cyc % TICK_DIV == 0);
         checks++;
         if (sample_tick !== exp_tick) begin
            errors++;
            $display("FAIL sample_tick cyc %0d: got %b want %b", cyc, sample_tick, exp_tick);
         end
         for (int c = 0; c < N_CH; c++) begin
            for (int k = 0; k < 3; k++) begin
               v = (k == K_PRESS) ? pb_press[c] : (k == K_REL) ? pb_release[c] : pb_long[c];
               if (v !== 1'b0) begin
                  idx = -1;
                  foreach (sb[i])
                     if (idx < 0 && sb[i].t == gcyc && sb[i].kind == k && sb[i].ch == c) idx = i;
                  checks++;
                  if (idx >= 0) sb.delete(idx);
                  else begin
                     errors++;
                     $display("FAIL unexpected %s ch%0d cyc %0d: got %b want 0", kname[k], c, cyc, v);
                  end
               end
            end
         end
         for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].t <= gcyc) begin
               checks++;
               errors++;
               $display("FAIL missed %s ch%0d: got 0 want 1 at global cyc %0d", kname[sb[i].kind],
                        sb[i].ch, sb[i].t);
               sb.delete(i);
            end
         end
      end
   end

   logic [N_CH-1:0] lvl_m;
   bit   pend  [N_CH];
   int   pend_d[N_CH];
   bit   armed [N_CH];
   int   due   [N_CH];

   initial begin
      int d, d_end, base, q, m1, lim, qr;
      bit rel_now;

      vec[0]  = '{1'b1, 2'b00, 3,  2'b00};
      vec[1]  = '{1'b0, 2'b00, 10, 2'b00};
      vec[2]  = '{1'b0, 2'b01, 5,  2'b00};
      vec[3]  = '{1'b0, 2'b00, 12, 2'b00};
      vec[4]  = '{1'b0, 2'b01, 16, 2'b01};
      vec[5]  = '{1'b0, 2'b10, 3,  2'b01};
      vec[6]  = '{1'b0, 2'b00, 3,  2'b01};
      vec[7]  = '{1'b0, 2'b10, 3,  2'b01};
      vec[8]  = '{1'b0, 2'b00, 3,  2'b01};
      vec[9]  = '{1'b0, 2'b10, 3,  2'b00};
      vec[10] = '{1'b0, 2'b00, 3,  2'b00};
      vec[11] = '{1'b0, 2'b10, 3,  2'b00};
      vec[12] = '{1'b0, 2'b00, 3,  2'b00};
      vec[13] = '{1'b0, 2'b00, 8,  2'b00};
      vec[14] = '{1'b0, 2'b10, 11, 2'b00};
      vec[15] = '{1'b1, 2'b10, 3,  2'b00};
      vec[16] = '{1'b0, 2'b10, 20, 2'b10};
      vec[17] = '{1'b0, 2'b11, 24, 2'b11};
      vec[18] = '{1'b0, 2'b00, 20, 2'b00};
      vec[19] = '{1'b0, 2'b11, 20, 2'b11};
      vec[20] = '{1'b0, 2'b11, 40, 2'b11};
      vec[21] = '{1'b0, 2'b00, 20, 2'b00};

      rst    = 1'b1;
      pb_raw = '0;
      lvl_m  = '0;
      for (int c = 0; c < N_CH; c++) begin
         pend[c] = 0; pend_d[c] = 0; armed[c] = 0; due[c] = 0;
      end
      @(posedge clk);
      #1;
      mon_en = 1'b1;

      for (int r = 0; r < 22; r++) begin
         rst    = vec[r].rst;
         pb_raw = vec[r].raw;
         d      = cyc;
         d_end  = cyc + vec[r].hold;
         base   = gcyc - cyc;
         if (vec[r].rst) begin
            lvl_m = '0;
            for (int c = 0; c < N_CH; c++) begin
               pend[c] = 0; armed[c] = 0;
            end
         end else begin
            for (int c = 0; c < N_CH; c++) begin
               rel_now = 0;
               qr = 0;
               if (vec[r].raw[c] != lvl_m[c]) begin
                  if (!pend[c]) begin
                     pend[c]   = 1;
                     pend_d[c] = d;
                  end
                  // first tick whose sampled s2 already holds the new value, then STABLE_CNT-1 more
                  m1 = (pend_d[c] + 2 + TICK_DIV - 1) / TICK_DIV;
                  q  = TICK_DIV * (m1 + STABLE_CNT - 1) + 1;
                  if (q - 2 <= d_end) begin
                     sb.push_back('{base + q, lvl_m[c] ? K_REL : K_PRESS, c});
                     if (!lvl_m[c]) begin
                        armed[c] = 1;
                        due[c]   = q + TICK_DIV * LONG_TICKS;
                     end else begin
                        rel_now = 1;
                        qr      = q;
                     end
                     lvl_m[c] = ~lvl_m[c];
                     pend[c]  = 0;
                  end
               end else begin
                  pend[c] = 0;
               end
               if (armed[c]) begin
                  lim = rel_now ? qr : d_end;
                  if (due[c] <= lim) begin
                     if (LONG_EN) sb.push_back('{base + due[c], K_LONG, c});
                     armed[c] = 0;
                  end
                  if (rel_now) armed[c] = 0;
               end
            end
         end
         repeat (vec[r].hold) @(posedge clk);
         #1;
         checks++;
         if (pb_level !== vec[r].exp_level) begin
            errors++;
            $display("FAIL level row %0d: got %b want %b", r, pb_level, vec[r].exp_level);
         end
      end

      repeat (12) @(posedge clk);
      #1;
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL scoreboard drain: got %0d pending want 0", sb.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
